// File: rtl/param_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : param_reg_bank
// Purpose  : DEPTH-entry bank of WIDTH-bit signed registers for the
//            regression datapath (coefficients, partial sums, sample history).
//            Write modes: direct load, signed saturating accumulate and
//            shift-in history. Also provides a sticky saturation flag, a
//            saturating shift counter and a full indicator.
// Ports    : clk      - rising-edge clock
//            rst      - asynchronous active-high reset
//            init     - synchronous clear of all state, wins over ld
//            ld       - write enable qualifying mode
//            mode     - 00 LOAD, 01 ACC, 10 SHIFT, 11 HOLD
//            wr_addr  - target entry for LOAD / ACC
//            in       - write data or addend
//            rd_addr  - read address
//            out      - combinational read of entry[rd_addr], 0 if out of range
//            ovf      - sticky saturation flag
//            count    - SHIFT operations since clear, saturating at DEPTH
//            full     - count == DEPTH
// Revision : 1.0  initial release
// ============================================================================
module param_reg_bank #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             ld,
  input  logic [1:0]       mode,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] in,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] out,
  output logic             ovf,
  output logic [CW-1:0]    count,
  output logic             full
);

  localparam logic [1:0] c_mode_load  = 2'b00;
  localparam logic [1:0] c_mode_acc   = 2'b01;
  localparam logic [1:0] c_mode_shift = 2'b10;

  localparam logic [WIDTH-1:0] c_sat_max = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_sat_min = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_ovf;
  logic [CW-1:0]    r_count;

  logic             w_wr_ok;
  logic [WIDTH-1:0] w_acc_src;
  logic [WIDTH:0]   w_sum;
  logic             w_acc_sat;
  logic [WIDTH-1:0] w_acc_val;

  // Extra bit so the compare also works when DEPTH == 2**AW.
  assign w_wr_ok = ({1'b0, wr_addr} < (AW+1)'(DEPTH));

  // Read and accumulate-source muxes are written as explicit loops so that
  // addresses beyond DEPTH-1 fall through to zero instead of indexing past
  // the array.
  always_comb begin
    out = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == AW'(i)) out = r_mem[i];
    end
  end

  always_comb begin
    w_acc_src = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_addr == AW'(i)) w_acc_src = r_mem[i];
    end
  end

  // Sign-extended sum; the two top bits disagree exactly when the true
  // result does not fit in WIDTH bits, and the top bit gives the direction.
  assign w_sum     = {w_acc_src[WIDTH-1], w_acc_src} + {in[WIDTH-1], in};
  assign w_acc_sat = (w_sum[WIDTH] != w_sum[WIDTH-1]);

  always_comb begin
    w_acc_val = w_sum[WIDTH-1:0];
    if (w_acc_sat) w_acc_val = w_sum[WIDTH] ? c_sat_min : c_sat_max;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else if (init) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else if (ld) begin
      case (mode)
        c_mode_load: begin
          for (int i = 0; i < DEPTH; i++) begin
            if (w_wr_ok && wr_addr == AW'(i)) r_mem[i] <= in;
          end
        end
        c_mode_acc: begin
          for (int i = 0; i < DEPTH; i++) begin
            if (w_wr_ok && wr_addr == AW'(i)) r_mem[i] <= w_acc_val;
          end
          if (w_wr_ok && w_acc_sat) r_ovf <= 1'b1;
        end
        c_mode_shift: begin
          r_mem[0] <= in;
          for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
          if (r_count < CW'(DEPTH)) r_count <= r_count + CW'(1);
        end
        default: ;  // HOLD
      endcase
    end
  end

  assign ovf   = r_ovf;
  assign count = r_count;
  assign full  = (r_count == CW'(DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_param_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_reg_bank
// Purpose  : Scoreboard bench for param_reg_bank (WIDTH=8, DEPTH=3, AW=2,
//            CW=2). Stimulus pushes hand-computed expectations; a monitor
//            pops and compares them on the falling clock edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_param_reg_bank;

  localparam logic [1:0] c_load  = 2'b00;
  localparam logic [1:0] c_acc   = 2'b01;
  localparam logic [1:0] c_shift = 2'b10;
  localparam logic [1:0] c_hold  = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       init;
  logic       ld;
  logic [1:0] mode;
  logic [1:0] wr_addr;
  logic [7:0] din;
  logic [1:0] rd_addr;
  logic [7:0] out;
  logic       ovf;
  logic [1:0] count;
  logic       full;

  typedef struct {
    string      name;
    logic [7:0] out;
    logic       ovf;
    logic [1:0] count;
    logic       full;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   failed = 0;

  param_reg_bank #(.WIDTH(8), .DEPTH(3), .AW(2), .CW(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .init    (init),
    .ld      (ld),
    .mode    (mode),
    .wr_addr (wr_addr),
    .in      (din),
    .rd_addr (rd_addr),
    .out     (out),
    .ovf     (ovf),
    .count   (count),
    .full    (full)
  );

  always #5 clk = ~clk;

  // Monitor: one queued expectation consumed per falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (out !== e.out || ovf !== e.ovf || count !== e.count || full !== e.full) begin
          failed++;
          $display("FAIL %s: got out=%h ovf=%b count=%0d full=%b, required out=%h ovf=%b count=%0d full=%b",
                   e.name, out, ovf, count, full, e.out, e.ovf, e.count, e.full);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  // Sets rd_addr, queues the expectation and lets the monitor consume it.
  task automatic expect_st(input string name, input logic [1:0] ra, input logic [7:0] o,
                           input logic ov, input logic [1:0] c, input logic f);
    exp_t e;
    rd_addr = ra;
    e.name = name; e.out = o; e.ovf = ov; e.count = c; e.full = f;
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic op(input logic [1:0] m, input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    ld = 1'b1; mode = m; wr_addr = a; din = d;
    @(posedge clk); #1;
    ld = 1'b0;
  endtask

  task automatic pulse_init(input logic with_ld);
    @(posedge clk); #1;
    init = 1'b1; ld = with_ld; mode = c_load; wr_addr = 2'd0; din = 8'hAA;
    @(posedge clk); #1;
    init = 1'b0; ld = 1'b0;
  endtask

  initial begin
    rst = 1'b1; init = 1'b0; ld = 1'b0; mode = c_hold;
    wr_addr = '0; din = '0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    expect_st("reset_state", 2'd0, 8'h00, 1'b0, 2'd0, 1'b0);

    // Asynchronous reset between edges
    for (int i = 0; i < 3; i++) op(c_load, 2'(i), 8'h55);
    expect_st("load55_e1", 2'd1, 8'h55, 1'b0, 2'd0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    expect_st("async_rst_e0", 2'd0, 8'h00, 1'b0, 2'd0, 1'b0);
    expect_st("async_rst_e2", 2'd2, 8'h00, 1'b0, 2'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // init beats a concurrent LOAD
    for (int i = 0; i < 3; i++) op(c_load, 2'(i), 8'h55);
    pulse_init(1'b1);
    expect_st("init_e0", 2'd0, 8'h00, 1'b0, 2'd0, 1'b0);
    expect_st("init_e1", 2'd1, 8'h00, 1'b0, 2'd0, 1'b0);

    // LOAD and read, including out-of-range address
    op(c_load, 2'd1, 8'h12);
    op(c_load, 2'd2, 8'h34);
    expect_st("read_e1", 2'd1, 8'h12, 1'b0, 2'd0, 1'b0);
    expect_st("read_e2", 2'd2, 8'h34, 1'b0, 2'd0, 1'b0);
    expect_st("read_e0", 2'd0, 8'h00, 1'b0, 2'd0, 1'b0);
    expect_st("read_oor", 2'd3, 8'h00, 1'b0, 2'd0, 1'b0);
    op(c_load, 2'd3, 8'h99);
    expect_st("oor_load_e0", 2'd0, 8'h00, 1'b0, 2'd0, 1'b0);
    expect_st("oor_load_e1", 2'd1, 8'h12, 1'b0, 2'd0, 1'b0);
    expect_st("oor_load_e2", 2'd2, 8'h34, 1'b0, 2'd0, 1'b0);
    expect_st("oor_load_rd3", 2'd3, 8'h00, 1'b0, 2'd0, 1'b0);

    // Saturating accumulate
    op(c_load, 2'd0, 8'd100);
    op(c_acc, 2'd0, 8'd20);
    expect_st("acc_120", 2'd0, 8'd120, 1'b0, 2'd0, 1'b0);
    op(c_acc, 2'd3, 8'h80);                 // out of range: no entry or ovf change
    expect_st("acc_oor_ign", 2'd0, 8'd120, 1'b0, 2'd0, 1'b0);
    op(c_acc, 2'd0, 8'd50);
    expect_st("acc_sat_pos", 2'd0, 8'h7F, 1'b1, 2'd0, 1'b0);
    op(c_load, 2'd1, 8'h9C);                // -100
    op(c_acc, 2'd1, 8'hC4);                 // -60
    expect_st("acc_sat_neg", 2'd1, 8'h80, 1'b1, 2'd0, 1'b0);
    op(c_load, 2'd2, 8'h01);
    expect_st("ovf_sticky", 2'd2, 8'h01, 1'b1, 2'd0, 1'b0);
    pulse_init(1'b0);
    expect_st("ovf_cleared", 2'd0, 8'h00, 1'b0, 2'd0, 1'b0);

    // Exact boundary: reaches max without saturating
    op(c_load, 2'd2, 8'h7E);
    op(c_acc, 2'd2, 8'h01);
    expect_st("acc_edge_max", 2'd2, 8'h7F, 1'b0, 2'd0, 1'b0);
    op(c_load, 2'd1, 8'h81);
    op(c_acc, 2'd1, 8'hFF);
    expect_st("acc_edge_min", 2'd1, 8'h80, 1'b0, 2'd0, 1'b0);

    // Shift history, count and full
    op(c_shift, 2'd2, 8'd1);
    expect_st("shift1", 2'd0, 8'd1, 1'b0, 2'd1, 1'b0);
    op(c_shift, 2'd2, 8'd2);
    expect_st("shift2", 2'd1, 8'd1, 1'b0, 2'd2, 1'b0);
    op(c_shift, 2'd2, 8'd3);
    expect_st("shift3", 2'd2, 8'd1, 1'b0, 2'd3, 1'b1);
    op(c_shift, 2'd2, 8'd4);
    expect_st("shift4_e0", 2'd0, 8'd4, 1'b0, 2'd3, 1'b1);
    expect_st("shift4_e1", 2'd1, 8'd3, 1'b0, 2'd3, 1'b1);
    expect_st("shift4_e2", 2'd2, 8'd2, 1'b0, 2'd3, 1'b1);

    // Same-cycle read of the entry being written
    @(posedge clk); #1;
    ld = 1'b1; mode = c_load; wr_addr = 2'd0; din = 8'h7F;
    expect_st("rw_same_old", 2'd0, 8'd4, 1'b0, 2'd3, 1'b1);
    @(posedge clk); #1;
    ld = 1'b0;
    expect_st("rw_same_new", 2'd0, 8'h7F, 1'b0, 2'd3, 1'b1);

    // HOLD with ld=1 changes nothing, ovf included
    op(c_acc, 2'd0, 8'h01);
    expect_st("acc_sat_again", 2'd0, 8'h7F, 1'b1, 2'd3, 1'b1);
    op(c_hold, 2'd1, 8'h55);
    expect_st("hold_e1", 2'd1, 8'd3, 1'b1, 2'd3, 1'b1);
    expect_st("hold_e0", 2'd0, 8'h7F, 1'b1, 2'd3, 1'b1);

    // Drain the scoreboard with a bound
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      failed++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/param_reg_bank.md
Name: param_reg_bank

Overview:
- Parametrised multi-entry register bank for the regression datapath, holding coefficient, partial-sum and sample-history values.
- Generalises the fixed-width init/ld registers and the sticky flag register into one block with DEPTH entries of WIDTH bits.
- Adds three write modes: direct load, signed saturating accumulate, and shift-in history.
- Adds a sticky overflow flag, a fill counter and a full indicator.

Parameters:
- WIDTH, 14: bit width of each entry; entries are two's-complement signed.
- DEPTH, 4: number of entries; must be >= 2; need not be a power of two.
- AW, 2: address width; must satisfy 2**AW >= DEPTH.
- CW, 3: fill-counter width; must satisfy 2**CW > DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- init  input  1  synchronous clear of all state; has priority over ld.
- ld  input  1  write enable; qualifies mode.
- mode  input  2  write mode: 00 LOAD, 01 ACC, 10 SHIFT, 11 HOLD.
- wr_addr  input  AW  target entry for LOAD and ACC.
- in  input  WIDTH  write data or addend.
- rd_addr  input  AW  read address.
- out  output  WIDTH  combinational read of entry[rd_addr].
- ovf  output  1  sticky saturation flag.
- count  output  CW  number of SHIFT operations since clear, saturating at DEPTH.
- full  output  1  high when count == DEPTH.

Behaviour:
- Reset (rst high, asynchronous):
  - all entries = 0, ovf = 0, count = 0, full = 0.
  - Reset mid-operation discards any pending write.
- Priority at each rising clk edge:
  - rst, then init, then ld.
  - init = 1: identical clear to reset, regardless of ld or mode.
  - ld = 0 and init = 0: all state holds.
- LOAD (ld = 1, mode 00):
  - entry[wr_addr] <= in. Other entries, ovf and count unchanged.
- ACC (ld = 1, mode 01):
  - Compute sum = entry[wr_addr] + in at WIDTH+1 bits, signed.
  - sum > 2**(WIDTH-1)-1: store the max positive value and set ovf.
  - sum < -2**(WIDTH-1): store the min negative value and set ovf.
  - Otherwise store sum[WIDTH-1:0].
  - ovf stays set until rst or init.
- SHIFT (ld = 1, mode 10):
  - entry[0] <= in; entry[i] <= entry[i-1] for i = 1..DEPTH-1; entry[DEPTH-1] old value is discarded.
  - wr_addr is ignored.
  - count <= count+1 if count < DEPTH, else count holds.
- HOLD (mode 11): no state change even when ld = 1.
- Out-of-range address (value >= DEPTH):
  - LOAD or ACC to that address is ignored: no entry change, no ovf change.
  - out reads 0.
- Read timing:
  - out is combinational from the current register contents.
  - Reading the address being written in the same cycle returns the old value; the new value is visible after the edge.
- full is combinational from count; no extra latency.
- Write latency is 1 cycle: the value is visible on out in the cycle after the ld edge.

Test Plan:
Use WIDTH=8, DEPTH=3, AW=2, CW=2 for all scenarios.
- Reset/clear:
  - LOAD 0x55 to entries 0..2, then assert rst asynchronously between edges -> out reads 0 at every address immediately; ovf=0, count=0.
  - Repeat the loads, then pulse init with ld=1, mode=LOAD -> all entries 0, no write occurs.
- LOAD and read:
  - LOAD 0x12 to addr 1, 0x34 to addr 2.
  - rd_addr=1 -> 0x12; rd_addr=2 -> 0x34; rd_addr=0 -> 0x00.
  - rd_addr=3 (out of range) -> 0x00; LOAD to addr 3 leaves all entries unchanged.
- ACC saturation:
  - LOAD 100 to addr 0, then ACC +20 -> 120, ovf=0.
  - ACC +50 -> 127, ovf=1.
  - LOAD -100 to addr 1, then ACC -60 -> -128; ovf stays 1.
  - ovf clears only after init.
- SHIFT and fill:
  - SHIFT in 1, 2, 3, 4 on consecutive cycles.
  - count goes 1, 2, 3, 3; full=1 from the third shift onward.
  - Final entries: e0=4, e1=3, e2=2.
- Same-cycle read/write and HOLD:
  - rd_addr=0 during LOAD 0x7F to addr 0 -> out shows old value that cycle, 0x7F next cycle.
  - ld=1 with mode=11 -> no entry, count or ovf change.
